rpu_desc_sched: RTL and testbench
=================================

# rpu_desc_sched

Descriptor scheduler between the packet-distribution front end and the RPU array. It accepts one 64-bit slot descriptor at a time and picks a destination RPU by round-robin over enabled RPUs that hold a free-slot credit. It offers the descriptor on that RPU's `in_desc`/`in_desc_valid`/`in_desc_taken` interface. Slot credits are consumed on dispatch and restored by slot-free reports derived from each RPU's `out_desc` path.

## Interface
- `RPU_COUNT`, 16: number of RPUs served; power of two, 2..16.
- `ID_WIDTH`, 4: `$clog2(RPU_COUNT)`.
- `SLOT_COUNT`, 16: slots per RPU; credits range 0..SLOT_COUNT.
- `DESC_WIDTH`, 64: descriptor width.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `s_desc`, in, DESC_WIDTH: incoming descriptor.
- `s_desc_valid`, in, 1: `s_desc` valid.
- `s_desc_ready`, out, 1: scheduler can accept.
- `m_desc`, out, DESC_WIDTH: descriptor broadcast to all RPUs.
- `m_desc_valid`, out, RPU_COUNT: one-hot offer; bit i drives RPU i's `in_desc_valid`.
- `m_desc_dest`, out, ID_WIDTH: index of the offered RPU.
- `m_desc_taken`, in, RPU_COUNT: per-RPU `in_desc_taken` pulses.
- `slot_free_valid`, in, 1: one slot freed.
- `slot_free_rpu`, in, ID_WIDTH: RPU whose slot was freed.
- `rpu_en`, in, RPU_COUNT: RPU i eligible; low while RPU i is in core reset.
- `credit_err`, out, 1: sticky; a credit overflow or an unexpected take occurred.
- `desc_count`, out, 32: descriptors dispatched, wraps at 2^32.

## Operation
- Per-RPU credit counter, `$clog2(SLOT_COUNT+1)` bits. Round-robin pointer `rr_ptr` (ID_WIDTH bits). Holding register for the descriptor.
- Three-state FSM:
  - EMPTY: `s_desc_ready`=1. On `s_desc_valid`, capture `s_desc` and go to ARB.
  - ARB: eligible(i) = `rpu_en[i]` and credit[i]>0. If any RPU is eligible, register grant = first eligible index searching `rr_ptr`, `rr_ptr`+1, ... (mod RPU_COUNT) and go to OFFER. If none is eligible, stay in ARB; the held descriptor is never dropped.
  - OFFER: `m_desc_valid` = onehot(grant), `m_desc_dest` = grant, `m_desc` = held descriptor.
    - On `m_desc_taken[grant]`: credit[grant] decrements, `rr_ptr` = grant+1 mod RPU_COUNT, `desc_count` increments, go to EMPTY.
    - If `rpu_en[grant]` is low while no take is seen: go to ARB; `m_desc_valid` clears on the next cycle.
- `m_desc` holds its value whenever the FSM is not in EMPTY. Outside OFFER, `m_desc_valid` = 0.
- Credit update per RPU i, evaluated each cycle:
  - If `rpu_en[i]`=0: credit[i] is forced to SLOT_COUNT and slot-free reports for i are ignored. A disabled RPU's slots are all free after its reset.
  - Otherwise, inc = `slot_free_valid` and `slot_free_rpu`==i; dec = a take accepted for i. Inc and dec together leave the credit unchanged.
  - Inc at SLOT_COUNT without dec: credit saturates at SLOT_COUNT and `credit_err` sets.
- `credit_err` also sets on any `m_desc_taken` bit asserted outside OFFER or on a non-granted index; such a take has no other effect.
- `slot_free_rpu` values ≥ RPU_COUNT are ignored.

## Timing
- Reset values (async on `rst_n` low):
  - state EMPTY, `s_desc_ready`=1.
  - `m_desc_valid`=0, `m_desc`=0, `m_desc_dest`=0.
  - all credits = SLOT_COUNT, `rr_ptr`=0.
  - `credit_err`=0, `desc_count`=0.
- Release of `rst_n` is synchronized internally: two-flop deassert.
- All outputs are registered. There is no combinational path from `s_desc_valid`, `m_desc_taken` or `slot_free_*` to any output.
- Latency: `s_desc` handshake at cycle 0 → ARB at 1 → `m_desc_valid` high at 2 when an RPU is eligible.
- Take at cycle t → EMPTY at t+1 (`s_desc_ready`=1). Minimum spacing is 3 cycles per descriptor.
- A credit decrement is visible to the next ARB evaluation. A slot-free at cycle t is visible to ARB at t+1.
- Reset mid-OFFER drops the held descriptor. Upstream must replay it.

## Test plan
- Round-robin with all 16 RPUs enabled, 16 descriptors back-to-back, immediate takes → `m_desc_dest` sequence 0,1,...,15. Each credit ends at 15 and `desc_count`=16.
- RPU 3 credit exhausted: 16 takes to RPU 3 with only RPU 3 enabled, then a 17th descriptor → FSM stays in ARB with `m_desc_valid`=0. A `slot_free` for RPU 3 → offer to RPU 3 appears 2 cycles later.
- Withdrawal: RPU 5 offered, then `rpu_en[5]` dropped → the offer is withdrawn and the descriptor is re-offered to RPU 6. Credit[5] reads 16 while disabled.
- Simultaneous take and slot-free on RPU 2 in the same cycle → credit[2] unchanged and `credit_err`=0.
- Errors: a `slot_free` to RPU 0 at credit 16 → credit stays 16 and `credit_err`=1. A stray `m_desc_taken[7]` while in EMPTY also sets `credit_err`; it stays set until reset.
- `rst_n` asserted mid-OFFER → all outputs return to their reset values asynchronously, and the first post-reset descriptor goes to RPU 0.

Source files
------------

// File: rtl/rpu_desc_sched_if.sv
// Descriptor handshake bundle between the front end, the scheduler and the RPU array.
// master is the scheduler's view; slave is the view of the front end plus the RPUs.
interface rpu_desc_sched_if #(
    parameter int RPU_COUNT  = 16,
    parameter int ID_WIDTH   = $clog2(RPU_COUNT),
    parameter int DESC_WIDTH = 64
);
    logic [DESC_WIDTH-1:0] s_desc;
    logic                  s_desc_valid;
    logic                  s_desc_ready;
    logic [DESC_WIDTH-1:0] m_desc;
    logic [RPU_COUNT-1:0]  m_desc_valid;
    logic [ID_WIDTH-1:0]   m_desc_dest;
    logic [RPU_COUNT-1:0]  m_desc_taken;

    modport master (
        input  s_desc,
        input  s_desc_valid,
        output s_desc_ready,
        output m_desc,
        output m_desc_valid,
        output m_desc_dest,
        input  m_desc_taken
    );

    modport slave (
        output s_desc,
        output s_desc_valid,
        input  s_desc_ready,
        input  m_desc,
        input  m_desc_valid,
        input  m_desc_dest,
        output m_desc_taken
    );
endinterface

// File: rtl/rpu_desc_sched.sv
// Credit-based round-robin descriptor scheduler feeding the RPU array.
// One descriptor in flight: EMPTY -> ARB -> OFFER -> EMPTY, all outputs registered.
module rpu_desc_sched #(
    parameter int RPU_COUNT  = 16,
    parameter int ID_WIDTH   = $clog2(RPU_COUNT),
    parameter int SLOT_COUNT = 16,
    parameter int DESC_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rpu_desc_sched_if.master     bus,
    input  logic                 slot_free_valid,
    input  logic [ID_WIDTH-1:0]  slot_free_rpu,
    input  logic [RPU_COUNT-1:0] rpu_en,
    output logic                 credit_err,
    output logic [31:0]          desc_count
);

    localparam int CW = $clog2(SLOT_COUNT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(SLOT_COUNT);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ARB   = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    function automatic logic [RPU_COUNT-1:0] onehot(input logic [ID_WIDTH-1:0] idx);
        logic [RPU_COUNT-1:0] v;
        v = {RPU_COUNT{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scans downward so the lowest distance from ptr is the last (winning) hit.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [RPU_COUNT-1:0] elig,
                                                    input logic [ID_WIDTH-1:0]  ptr);
        logic [ID_WIDTH-1:0] idx;
        logic [ID_WIDTH-1:0] pick;
        pick = ptr;
        for (int k = RPU_COUNT - 1; k >= 0; k--) begin
            idx  = ptr + ID_WIDTH'(k);
            pick = elig[idx] ? idx : pick;
        end
        return pick;
    endfunction

    logic [1:0]            rst_sync_r;
    logic                  rst_int_n;

    state_t                state_r;
    state_t                state_next_s;
    logic [ID_WIDTH-1:0]   grant_r;
    logic [ID_WIDTH-1:0]   grant_next_s;
    logic [ID_WIDTH-1:0]   rr_ptr_r;
    logic [DESC_WIDTH-1:0] desc_r;
    logic                  ready_r;
    logic [RPU_COUNT-1:0]  valid_r;
    logic                  err_r;
    logic [31:0]           count_r;
    logic [CW-1:0]         credit_r      [RPU_COUNT];
    logic [CW-1:0]         credit_next_s [RPU_COUNT];

    logic                  capture_s;
    logic                  take_acc_s;
    logic [RPU_COUNT-1:0]  elig_s;
    logic [RPU_COUNT-1:0]  inc_s;
    logic [RPU_COUNT-1:0]  dec_s;
    logic [RPU_COUNT-1:0]  take_mask_s;
    logic                  stray_s;
    logic                  overflow_s;

    // Reset release synchronizer; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_r[1];

    // Per-RPU eligibility and credit increment/decrement requests.
    always_comb begin
        elig_s = {RPU_COUNT{1'b0}};
        inc_s  = {RPU_COUNT{1'b0}};
        dec_s  = {RPU_COUNT{1'b0}};
        for (int i = 0; i < RPU_COUNT; i++) begin
            elig_s[i] = rpu_en[i] && (credit_r[i] != {CW{1'b0}});
            inc_s[i]  = slot_free_valid && (32'(slot_free_rpu) == 32'(i));
            dec_s[i]  = take_acc_s && (grant_r == ID_WIDTH'(i));
        end
    end

    // Any take other than the one accepted for the current offer is an error.
    always_comb begin
        if (state_r == ST_OFFER) begin
            take_mask_s = onehot(grant_r);
        end else begin
            take_mask_s = {RPU_COUNT{1'b0}};
        end
        stray_s = |(bus.m_desc_taken & ~take_mask_s);
    end

    // Credit next-state: disabled RPUs read full, simultaneous inc/dec cancel.
    always_comb begin
        credit_next_s = credit_r;
        overflow_s    = 1'b0;
        for (int i = 0; i < RPU_COUNT; i++) begin
            if (!rpu_en[i]) begin
                credit_next_s[i] = CREDIT_MAX;
            end else if (inc_s[i] && !dec_s[i]) begin
                if (credit_r[i] == CREDIT_MAX) begin
                    overflow_s = 1'b1;
                end else begin
                    credit_next_s[i] = credit_r[i] + CW'(1);
                end
            end else if (dec_s[i] && !inc_s[i]) begin
                if (credit_r[i] != {CW{1'b0}}) begin
                    credit_next_s[i] = credit_r[i] - CW'(1);
                end else begin
                    credit_next_s[i] = credit_r[i];
                end
            end else begin
                credit_next_s[i] = credit_r[i];
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        capture_s    = 1'b0;
        take_acc_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (bus.s_desc_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_ARB;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ARB: begin
                if (|elig_s) begin
                    grant_next_s = rr_pick(elig_s, rr_ptr_r);
                    state_next_s = ST_OFFER;
                end else begin
                    state_next_s = ST_ARB;
                end
            end
            ST_OFFER: begin
                if (bus.m_desc_taken[grant_r]) begin
                    take_acc_s   = 1'b1;
                    state_next_s = ST_EMPTY;
                end else if (!rpu_en[grant_r]) begin
                    state_next_s = ST_ARB;
                end else begin
                    state_next_s = ST_OFFER;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_r  <= ST_EMPTY;
            grant_r  <= {ID_WIDTH{1'b0}};
            rr_ptr_r <= {ID_WIDTH{1'b0}};
            desc_r   <= {DESC_WIDTH{1'b0}};
            ready_r  <= 1'b1;
            valid_r  <= {RPU_COUNT{1'b0}};
            err_r    <= 1'b0;
            count_r  <= 32'd0;
            for (int i = 0; i < RPU_COUNT; i++) begin
                credit_r[i] <= CREDIT_MAX;
            end
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
            ready_r <= (state_next_s == ST_EMPTY);
            valid_r <= (state_next_s == ST_OFFER) ? onehot(grant_next_s) : {RPU_COUNT{1'b0}};
            err_r   <= err_r | overflow_s | stray_s;
            if (capture_s) begin
                desc_r <= bus.s_desc;
            end
            if (take_acc_s) begin
                rr_ptr_r <= grant_r + ID_WIDTH'(1);
                count_r  <= count_r + 32'd1;
            end
            for (int i = 0; i < RPU_COUNT; i++) begin
                credit_r[i] <= credit_next_s[i];
            end
        end
    end

    assign bus.s_desc_ready = ready_r;
    assign bus.m_desc       = desc_r;
    assign bus.m_desc_valid = valid_r;
    assign bus.m_desc_dest  = grant_r;
    assign credit_err       = err_r;
    assign desc_count       = count_r;

endmodule

// File: tb/tb_rpu_desc_sched.sv
// Directed testbench for rpu_desc_sched: round-robin, credit exhaustion,
// withdrawal, simultaneous take/free, error flag and asynchronous reset.
module tb_rpu_desc_sched;
    localparam int N = 16;

    logic        clk;
    logic        rst_n;
    logic        slot_free_valid;
    logic [3:0]  slot_free_rpu;
    logic [15:0] rpu_en;
    logic        credit_err;
    logic [31:0] desc_count;
    logic [31:0] exp_count;
    int          tests_run = 0;
    int          tests_failed = 0;

    rpu_desc_sched_if #(.RPU_COUNT(16), .ID_WIDTH(4), .DESC_WIDTH(64)) bus ();

    rpu_desc_sched #(
        .RPU_COUNT(16), .ID_WIDTH(4), .SLOT_COUNT(16), .DESC_WIDTH(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .slot_free_valid(slot_free_valid),
        .slot_free_rpu(slot_free_rpu),
        .rpu_en(rpu_en),
        .credit_err(credit_err),
        .desc_count(desc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        bus.s_desc       = d;
        bus.s_desc_valid = 1'b1;
        tick();
        bus.s_desc_valid = 1'b0;
    endtask

    task automatic take(input logic [15:0] oh);
        bus.m_desc_taken = oh;
        tick();
        bus.m_desc_taken = 16'd0;
        exp_count = exp_count + 32'd1;
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        bus.s_desc       = 64'd0;
        bus.s_desc_valid = 1'b0;
        bus.m_desc_taken = 16'd0;
        slot_free_valid  = 1'b0;
        slot_free_rpu    = 4'd0;
        rpu_en           = 16'hFFFF;
        exp_count        = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (bus.s_desc_ready !== 1'b1 || bus.m_desc_valid !== 16'd0 || bus.m_desc !== 64'd0 ||
            bus.m_desc_dest !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b valid=%h desc=%h dest=%0d, want 1/0000/0/0",
                     bus.s_desc_ready, bus.m_desc_valid, bus.m_desc, bus.m_desc_dest);
        end
        tests_run++;
        if (credit_err !== 1'b0 || desc_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_status: err=%b count=%0d, want 0/0", credit_err, desc_count);
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (dut.credit_r[i] !== 5'd16) begin
                tests_failed++;
                $display("FAIL reset_credit[%0d]: got %0d want 16", i, dut.credit_r[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [63:0] d;
        logic [15:0] oh;
        rpu_en = 16'hFFFF;
        for (int k = 0; k < N; k++) begin
            d  = 64'hA5A5_0000_0000_0000 | 64'(k);
            oh = 16'd1 << k;
            push(d);
            tests_run++;
            if (bus.s_desc_ready !== 1'b0 || bus.m_desc_valid !== 16'd0) begin
                tests_failed++;
                $display("FAIL rr_arb[%0d]: ready=%b valid=%h, want 0/0000", k, bus.s_desc_ready, bus.m_desc_valid);
            end
            tick();
            tests_run++;
            if (bus.m_desc_valid !== oh || bus.m_desc_dest !== 4'(k) || bus.m_desc !== d) begin
                tests_failed++;
                $display("FAIL rr_offer[%0d]: valid=%h dest=%0d desc=%h, want %h/%0d/%h",
                         k, bus.m_desc_valid, bus.m_desc_dest, bus.m_desc, oh, k, d);
            end
            take(oh);
            tests_run++;
            if (bus.s_desc_ready !== 1'b1 || bus.m_desc_valid !== 16'd0) begin
                tests_failed++;
                $display("FAIL rr_empty[%0d]: ready=%b valid=%h, want 1/0000", k, bus.s_desc_ready, bus.m_desc_valid);
            end
        end
        tests_run++;
        if (desc_count !== 32'd16) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d want 16", desc_count);
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (dut.credit_r[i] !== 5'd15) begin
                tests_failed++;
                $display("FAIL rr_credit[%0d]: got %0d want 15", i, dut.credit_r[i]);
            end
        end
    endtask

    task automatic test_withdraw();
        logic [63:0] d;
        d = 64'h0123_4567_89AB_CDEF;
        rpu_en = 16'hFFE0;
        push(d);
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'h0020 || bus.m_desc_dest !== 4'd5) begin
            tests_failed++;
            $display("FAIL wd_offer5: valid=%h dest=%0d, want 0020/5", bus.m_desc_valid, bus.m_desc_dest);
        end
        rpu_en = 16'hFFC0;
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'd0 || bus.s_desc_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_withdrawn: valid=%h ready=%b, want 0000/0", bus.m_desc_valid, bus.s_desc_ready);
        end
        tests_run++;
        if (dut.credit_r[5] !== 5'd16) begin
            tests_failed++;
            $display("FAIL wd_credit5: got %0d want 16", dut.credit_r[5]);
        end
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'h0040 || bus.m_desc_dest !== 4'd6 || bus.m_desc !== d) begin
            tests_failed++;
            $display("FAIL wd_reoffer6: valid=%h dest=%0d desc=%h, want 0040/6/%h",
                     bus.m_desc_valid, bus.m_desc_dest, bus.m_desc, d);
        end
        take(16'h0040);
        tests_run++;
        if (dut.credit_r[6] !== 5'd14 || desc_count !== exp_count) begin
            tests_failed++;
            $display("FAIL wd_after: credit6=%0d count=%0d, want 14/%0d", dut.credit_r[6], desc_count, exp_count);
        end
    endtask

    task automatic test_credit_exhaust();
        rpu_en = 16'h0000;
        tick();
        rpu_en = 16'h0008;
        for (int k = 0; k < N; k++) begin
            push(64'hC3C3_0000_0000_0000 | 64'(k));
            tick();
            tests_run++;
            if (bus.m_desc_valid !== 16'h0008 || bus.m_desc_dest !== 4'd3) begin
                tests_failed++;
                $display("FAIL ex_offer[%0d]: valid=%h dest=%0d, want 0008/3", k, bus.m_desc_valid, bus.m_desc_dest);
            end
            take(16'h0008);
        end
        tests_run++;
        if (dut.credit_r[3] !== 5'd0) begin
            tests_failed++;
            $display("FAIL ex_credit_zero: got %0d want 0", dut.credit_r[3]);
        end
        push(64'hDEAD_BEEF_0000_0011);
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'd0 || bus.s_desc_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ex_stall: valid=%h ready=%b, want 0000/0", bus.m_desc_valid, bus.s_desc_ready);
        end
        slot_free_valid = 1'b1;
        slot_free_rpu   = 4'd3;
        tick();
        slot_free_valid = 1'b0;
        tests_run++;
        if (bus.m_desc_valid !== 16'd0) begin
            tests_failed++;
            $display("FAIL ex_free_t1: valid=%h want 0000", bus.m_desc_valid);
        end
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'h0008 || bus.m_desc_dest !== 4'd3 || bus.m_desc !== 64'hDEAD_BEEF_0000_0011) begin
            tests_failed++;
            $display("FAIL ex_free_t2: valid=%h dest=%0d desc=%h, want 0008/3/deadbeef00000011",
                     bus.m_desc_valid, bus.m_desc_dest, bus.m_desc);
        end
        take(16'h0008);
        tests_run++;
        if (desc_count !== exp_count || dut.credit_r[3] !== 5'd0) begin
            tests_failed++;
            $display("FAIL ex_after: count=%0d credit3=%0d, want %0d/0", desc_count, dut.credit_r[3], exp_count);
        end
    endtask

    task automatic test_simultaneous();
        rpu_en = 16'h0000;
        tick();
        rpu_en = 16'h0004;
        push(64'h0000_0000_0000_0222);
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'h0004) begin
            tests_failed++;
            $display("FAIL sim_offer2: valid=%h want 0004", bus.m_desc_valid);
        end
        slot_free_valid = 1'b1;
        slot_free_rpu   = 4'd2;
        take(16'h0004);
        slot_free_valid = 1'b0;
        tests_run++;
        if (dut.credit_r[2] !== 5'd16 || credit_err !== 1'b0 || desc_count !== exp_count) begin
            tests_failed++;
            $display("FAIL sim_credit: credit2=%0d err=%b count=%0d, want 16/0/%0d",
                     dut.credit_r[2], credit_err, desc_count, exp_count);
        end
    endtask

    task automatic test_errors();
        rpu_en = 16'hFFFF;
        tick();
        tests_run++;
        if (credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clean: got %b want 0", credit_err);
        end
        bus.m_desc_taken = 16'h0080;
        tick();
        bus.m_desc_taken = 16'd0;
        tests_run++;
        if (credit_err !== 1'b1 || desc_count !== exp_count || bus.s_desc_ready !== 1'b1 ||
            dut.credit_r[7] !== 5'd16) begin
            tests_failed++;
            $display("FAIL err_stray: err=%b count=%0d ready=%b credit7=%0d, want 1/%0d/1/16",
                     credit_err, desc_count, bus.s_desc_ready, dut.credit_r[7], exp_count);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (credit_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got %b want 1", credit_err);
        end
        apply_reset();
        tests_run++;
        if (credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_cleared: got %b want 0", credit_err);
        end
        slot_free_valid = 1'b1;
        slot_free_rpu   = 4'd0;
        tick();
        slot_free_valid = 1'b0;
        tests_run++;
        if (dut.credit_r[0] !== 5'd16 || credit_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_overflow: credit0=%0d err=%b, want 16/1", dut.credit_r[0], credit_err);
        end
    endtask

    task automatic test_reset_mid_offer();
        apply_reset();
        push(64'h1111_1111_1111_1111);
        tick();
        take(16'h0001);
        push(64'h2222_2222_2222_2222);
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'h0002 || bus.m_desc_dest !== 4'd1) begin
            tests_failed++;
            $display("FAIL rst_pre_offer: valid=%h dest=%0d, want 0002/1", bus.m_desc_valid, bus.m_desc_dest);
        end
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (bus.m_desc_valid !== 16'd0 || bus.s_desc_ready !== 1'b1 || bus.m_desc !== 64'd0 ||
            bus.m_desc_dest !== 4'd0 || desc_count !== 32'd0 || credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: valid=%h ready=%b desc=%h dest=%0d count=%0d err=%b, want all reset",
                     bus.m_desc_valid, bus.s_desc_ready, bus.m_desc, bus.m_desc_dest, desc_count, credit_err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        exp_count = 32'd0;
        tick();
        tick();
        tick();
        push(64'h3333_3333_3333_3333);
        tick();
        tests_run++;
        if (bus.m_desc_valid !== 16'h0001 || bus.m_desc_dest !== 4'd0 || bus.m_desc !== 64'h3333_3333_3333_3333) begin
            tests_failed++;
            $display("FAIL rst_first_dest: valid=%h dest=%0d desc=%h, want 0001/0/3333333333333333",
                     bus.m_desc_valid, bus.m_desc_dest, bus.m_desc);
        end
        take(16'h0001);
        tests_run++;
        if (desc_count !== exp_count) begin
            tests_failed++;
            $display("FAIL rst_count: got %0d want %0d", desc_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_withdraw();
        test_credit_exhaust();
        test_simultaneous();
        test_errors();
        test_reset_mid_offer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
